// File: rtl/rx_medidas_7e1_if.sv
// Serial line plus decoded-measurement bundle of the 7E1 sensor message receiver.
// master = the receiver producing measurements; slave = line driver / host consumer.
interface rx_medidas_7e1_if;
  logic        entrada_serial;
  logic [11:0] medida1;
  logic [11:0] medida2;
  logic [11:0] medida3;
  logic        pronto;
  logic        erro;
  logic [6:0]  caractere;
  logic        tem_caractere;
  logic [3:0]  db_estado;

  modport master (
    input  entrada_serial,
    output medida1, medida2, medida3, pronto, erro, caractere, tem_caractere, db_estado
  );

  modport slave (
    output entrada_serial,
    input  medida1, medida2, medida3, pronto, erro, caractere, tem_caractere, db_estado
  );
endinterface

// File: rtl/rx_medidas_7e1.sv
// 7E1 UART receiver that parses "hhh#hhh#hhh#" into three 12-bit BCD distances,
// published atomically with a one-cycle pronto pulse.
module rx_medidas_7e1 #(
  parameter int DIV          = 434,
  parameter int IDLE_TIMEOUT = 8680
) (
  input logic              clock,
  input logic              reset,
  rx_medidas_7e1_if.master bus
);
  localparam int CW = $clog2(DIV + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_CYC  = CW'(DIV);
  localparam logic [CW-1:0] HALF_CYC = CW'(DIV / 2);
  localparam logic [CW-1:0] ONE_CYC  = CW'(1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(IDLE_TIMEOUT);

  typedef enum logic [3:0] {
    ESPERA   = 4'd0,
    START    = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    STOP     = 4'd4,
    ENTREGA  = 4'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    data_q, data_d;
  logic          par_err_q, par_err_d;
  logic          rx_err_q, rx_err_d;
  logic [6:0]    char_q, char_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [1:0]    slot_q, slot_d;
  logic [1:0]    ndig_q, ndig_d;
  logic [11:0]   shadow_q, shadow_d;
  logic [11:0]   buf1_q, buf1_d, buf2_q, buf2_d;
  logic [11:0]   med1_q, med1_d, med2_q, med2_d, med3_q, med3_d;
  logic          descarta_q, descarta_d;
  logic          pronto_q, pronto_d;
  logic          erro_q, erro_d;

  logic fall, timeout, is_digit, is_hash;

  // Synchronizer flops reset low so a line already low at release never looks like a start.
  assign fall     = rx_prev_q & ~rx_sync_q;
  assign timeout  = (state_q == ESPERA) && (idle_q == IDLE_MAX);
  assign is_digit = (char_q[6:4] == 3'b011) && (char_q[3:0] <= 4'd9);
  assign is_hash  = (char_q == 7'h23);

  // Receiver: all sample points are counted from start detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    rx_err_d  = rx_err_q;
    char_d    = char_q;
    idle_d    = idle_q;
    unique case (state_q)
      ESPERA: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
          cnt_d   = ONE_CYC;
          idle_d  = '0;
        end else if (idle_q != IDLE_MAX) begin
          idle_d = idle_q + 1'b1;
        end
      end
      START: if (cnt_q == HALF_CYC) begin
        state_d = rx_sync_q ? ESPERA : DADOS;
        cnt_d   = ONE_CYC;
        bit_d   = '0;
      end
      DADOS: if (cnt_q == BIT_CYC) begin
        data_d = {rx_sync_q, data_q[6:1]};
        cnt_d  = ONE_CYC;
        if (bit_q == 3'd6) state_d = PARIDADE;
        else               bit_d   = bit_q + 1'b1;
      end
      PARIDADE: if (cnt_q == BIT_CYC) begin
        par_err_d = (^data_q) ^ rx_sync_q;
        cnt_d     = ONE_CYC;
        state_d   = STOP;
      end
      STOP: if (cnt_q == BIT_CYC) begin
        rx_err_d = par_err_q | ~rx_sync_q;
        if (!par_err_q && rx_sync_q) char_d = data_q;
        state_d = ENTREGA;
      end
      ENTREGA: begin
        cnt_d   = '0;
        state_d = ESPERA;
      end
      default: state_d = ESPERA;
    endcase
  end

  // Message parser, evaluated once per delivered character.
  always_comb begin
    slot_d     = slot_q;
    ndig_d     = ndig_q;
    shadow_d   = shadow_q;
    buf1_d     = buf1_q;
    buf2_d     = buf2_q;
    med1_d     = med1_q;
    med2_d     = med2_q;
    med3_d     = med3_q;
    descarta_d = descarta_q;
    pronto_d   = 1'b0;
    erro_d     = 1'b0;
    if (timeout) begin
      slot_d     = '0;
      ndig_d     = '0;
      shadow_d   = '0;
      descarta_d = 1'b0;
    end
    if (state_q == ENTREGA) begin
      if (rx_err_q || (!descarta_q && !(is_digit && ndig_q != 2'd3) && !(is_hash && ndig_q == 2'd3))) begin
        erro_d     = 1'b1;
        slot_d     = '0;
        ndig_d     = '0;
        shadow_d   = '0;
        descarta_d = 1'b1;
      end else if (!descarta_q && is_digit) begin
        shadow_d = {shadow_q[7:0], char_q[3:0]};
        ndig_d   = ndig_q + 1'b1;
      end else if (!descarta_q) begin
        ndig_d   = '0;
        shadow_d = '0;
        unique case (slot_q)
          2'd0:    begin buf1_d = shadow_q; slot_d = 2'd1; end
          2'd1:    begin buf2_d = shadow_q; slot_d = 2'd2; end
          default: begin
            med1_d   = buf1_q;
            med2_d   = buf2_q;
            med3_d   = shadow_q;
            pronto_d = 1'b1;
            slot_d   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ESPERA;
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      char_q     <= '0;
      idle_q     <= '0;
      slot_q     <= '0;
      ndig_q     <= '0;
      shadow_q   <= '0;
      buf1_q     <= '0;
      buf2_q     <= '0;
      med1_q     <= '0;
      med2_q     <= '0;
      med3_q     <= '0;
      descarta_q <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      rx_meta_q  <= bus.entrada_serial;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      rx_err_q   <= rx_err_d;
      char_q     <= char_d;
      idle_q     <= idle_d;
      slot_q     <= slot_d;
      ndig_q     <= ndig_d;
      shadow_q   <= shadow_d;
      buf1_q     <= buf1_d;
      buf2_q     <= buf2_d;
      med1_q     <= med1_d;
      med2_q     <= med2_d;
      med3_q     <= med3_d;
      descarta_q <= descarta_d;
      pronto_q   <= pronto_d;
      erro_q     <= erro_d;
    end
  end

  assign bus.medida1       = med1_q;
  assign bus.medida2       = med2_q;
  assign bus.medida3       = med3_q;
  assign bus.pronto        = pronto_q;
  assign bus.erro          = erro_q;
  assign bus.caractere     = char_q;
  assign bus.tem_caractere = (state_q == ENTREGA) && !rx_err_q;
  assign bus.db_estado     = state_q;
endmodule

// File: tb/tb_rx_medidas_7e1.sv
// Randomized scoreboard bench for rx_medidas_7e1: a message-level model predicts
// characters, errors and completed messages; a monitor compares as the DUT emits them.
module tb_rx_medidas_7e1;
  localparam int DIV    = 8;
  localparam int IDLE_T = 200;
  localparam int LONG_IDLE = IDLE_T + 60;

  logic clock = 1'b0;
  logic reset = 1'b0;
  rx_medidas_7e1_if bus ();

  rx_medidas_7e1 #(.DIV(DIV), .IDLE_TIMEOUT(IDLE_T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0]  exp_chr[$];
  logic [35:0] exp_msg[$];
  int          exp_err[$];

  // Reference model: message text is gathered per field; a field is 3 digits then '#'.
  int          m_fields[$];
  int          m_digits;
  int          m_value;
  bit          m_disc;
  logic [35:0] m_last;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got a pulse expected none", name);
  endtask

  function automatic void model_clear();
    m_fields.delete();
    m_digits = 0;
    m_value  = 0;
  endfunction

  function automatic void model_idle();
    model_clear();
    m_disc = 1'b0;
  endfunction

  function automatic void model_char(input logic [6:0] c, input bit bad);
    int d;
    if (bad) begin
      exp_err.push_back(1);
      model_clear();
      m_disc = 1'b1;
      return;
    end
    exp_chr.push_back(c);
    if (m_disc) return;
    d = int'(c) - 48;
    if (d >= 0 && d <= 9 && m_digits < 3) begin
      m_value  = m_value * 16 + d;
      m_digits = m_digits + 1;
    end else if (c == 7'h23 && m_digits == 3) begin
      m_fields.push_back(m_value);
      m_value  = 0;
      m_digits = 0;
      if (m_fields.size() == 3) begin
        m_last = {12'(m_fields[0]), 12'(m_fields[1]), 12'(m_fields[2])};
        exp_msg.push_back(m_last);
        m_fields.delete();
      end
    end else begin
      exp_err.push_back(1);
      model_clear();
      m_disc = 1'b1;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop, input int gap);
    logic p;
    int   g;
    p = (^c) ^ bad_par;
    g = (bad_stop && gap < 2) ? 2 : gap;
    model_char(c, bad_par | bad_stop);
    bus.entrada_serial = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 7; i++) begin
      bus.entrada_serial = c[i];
      wait_cyc(DIV);
    end
    bus.entrada_serial = p;
    wait_cyc(DIV);
    bus.entrada_serial = ~bad_stop;
    wait_cyc(DIV);
    bus.entrada_serial = 1'b1;
    if (g > 0) wait_cyc(g);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(7'(s[i]), 1'b0, 1'b0, int'($urandom_range(0, 6)));
  endtask

  task automatic long_idle();
    wait_cyc(LONG_IDLE);
    model_idle();
  endtask

  task automatic check_held(input string tag);
    check({tag, "_medida1"}, 36'(bus.medida1), 36'(m_last[35:24]));
    check({tag, "_medida2"}, 36'(bus.medida2), 36'(m_last[23:12]));
    check({tag, "_medida3"}, 36'(bus.medida3), 36'(m_last[11:0]));
    check({tag, "_chr_pending"}, 36'(exp_chr.size()), 36'd0);
    check({tag, "_err_pending"}, 36'(exp_err.size()), 36'd0);
    check({tag, "_msg_pending"}, 36'(exp_msg.size()), 36'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_medida1"}, 36'(bus.medida1), 36'd0);
    check({tag, "_medida2"}, 36'(bus.medida2), 36'd0);
    check({tag, "_medida3"}, 36'(bus.medida3), 36'd0);
    check({tag, "_pronto"}, 36'(bus.pronto), 36'd0);
    check({tag, "_erro"}, 36'(bus.erro), 36'd0);
    check({tag, "_caractere"}, 36'(bus.caractere), 36'd0);
    check({tag, "_tem_caractere"}, 36'(bus.tem_caractere), 36'd0);
    check({tag, "_db_estado"}, 36'(bus.db_estado), 36'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic [3:0] prev_estado = 4'd0;
  always @(negedge clock) begin
    logic [35:0] m;
    if (reset) begin
      if (bus.tem_caractere) begin
        if (exp_chr.size() == 0) fail_unexpected("tem_caractere");
        else begin
          check("caractere", 36'(bus.caractere), 36'(exp_chr.pop_front()));
          check("tem_caractere_state", 36'(bus.db_estado), 36'd5);
        end
      end
      if (bus.erro) begin
        if (exp_err.size() == 0) fail_unexpected("erro");
        else begin
          void'(exp_err.pop_front());
          check("erro_latency", 36'(prev_estado), 36'd5);
        end
      end
      if (bus.pronto) begin
        if (exp_msg.size() == 0) fail_unexpected("pronto");
        else begin
          m = exp_msg.pop_front();
          check("pronto_medida1", 36'(bus.medida1), 36'(m[35:24]));
          check("pronto_medida2", 36'(bus.medida2), 36'(m[23:12]));
          check("pronto_medida3", 36'(bus.medida3), 36'(m[11:0]));
          check("pronto_latency", 36'(prev_estado), 36'd5);
        end
      end
      prev_estado = bus.db_estado;
    end else begin
      prev_estado = 4'd0;
    end
  end

  initial begin
    string s;
    int    bad_pos, kind;
    bus.entrada_serial = 1'b1;
    m_last = '0;
    model_idle();
    wait_cyc(3);
    #1 check_zero("reset");
    reset = 1'b1;
    wait_cyc(10);
    check("post_reset_estado", 36'(bus.db_estado), 36'd0);

    // Clean message.
    send_str("123#045#999#");
    wait_cyc(30);
    check_held("msg1");

    // Parity error inside field 2, rest discarded, then timeout and a good message.
    send_str("123#");
    send_char(7'h30, 1'b1, 1'b0, 3);
    send_str("45#999#");
    wait_cyc(30);
    check_held("parity");
    long_idle();
    send_str("321#654#987#");
    wait_cyc(30);
    check_held("after_parity");

    // '#' after two digits.
    send_str("12#");
    send_str("3#456#789#");
    long_idle();
    check_held("short_field");

    // Framing error on the 5th character.
    send_str("123#");
    send_char(7'h30, 1'b0, 1'b1, 4);
    send_str("45#999#");
    long_idle();
    check_held("framing");

    // One-cycle low glitch on an idle line.
    bus.entrada_serial = 1'b0;
    wait_cyc(1);
    bus.entrada_serial = 1'b1;
    wait_cyc(DIV + 6);
    check("glitch_estado", 36'(bus.db_estado), 36'd0);
    long_idle();
    check_held("glitch");

    // Partial message abandoned by timeout.
    send_str("123#04");
    long_idle();
    send_str("777#888#999#");
    wait_cyc(30);
    check_held("timeout_resync");

    // Random messages, some with one corrupted character.
    for (int k = 0; k < 6; k++) begin
      s = "";
      for (int f = 0; f < 3; f++) begin
        for (int d = 0; d < 3; d++) s = {s, string'(8'(48 + $urandom_range(0, 9)))};
        s = {s, "#"};
      end
      bad_pos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
      kind    = int'($urandom_range(0, 2));
      for (int i = 0; i < 12; i++) begin
        if (i == bad_pos && kind == 0)      send_char(7'(s[i]), 1'b1, 1'b0, int'($urandom_range(0, 6)));
        else if (i == bad_pos && kind == 1) send_char(7'(s[i]), 1'b0, 1'b1, int'($urandom_range(0, 6)));
        else if (i == bad_pos)              send_char(7'h41, 1'b0, 1'b0, int'($urandom_range(0, 6)));
        else                                send_char(7'(s[i]), 1'b0, 1'b0, int'($urandom_range(0, 6)));
      end
      if (bad_pos >= 0) long_idle();
      else              wait_cyc(30);
      check_held("random");
    end

    // Reset during the data bits of character 7.
    send_str("111#22");
    wait_cyc(4);
    check("pre_reset_chr_pending", 36'(exp_chr.size()), 36'd0);
    bus.entrada_serial = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 3; i++) begin
      bus.entrada_serial = (i == 1);
      wait_cyc(DIV);
    end
    check("mid_frame_estado", 36'(bus.db_estado), 36'd2);
    reset = 1'b0;
    #1 check_zero("mid_reset");
    exp_chr.delete();
    exp_err.delete();
    exp_msg.delete();
    model_idle();
    m_last = '0;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(4);
    bus.entrada_serial = 1'b1;
    wait_cyc(20);
    check("release_low_estado", 36'(bus.db_estado), 36'd0);
    send_str("246#135#802#");
    wait_cyc(30);
    check_held("after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
